ecc_job_ctrl: RTL and testbench

Host-side launcher that drives the ECC scalar-multiplication core (`Top_ting`), the block that currently only the bench drives.
- Accepts one job (curve parameter a, prime, scalar k, base point Px/Py) over a valid/ready handshake.
- Clears and starts the core, then waits for its done flag, with a watchdog.
- Returns the kP result, or an error code, over a second valid/ready handshake.
- Sits between the system command path and the ECC core; exactly one job is in flight at a time.

---
 rtl/ecc_job_ctrl.sv | 118 +++++++++++
 tb/tb_ecc_job_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_job_ctrl.sv
// Single-job launcher for the ECC scalar-multiplication core: accepts a job,
// clears and starts the core, waits for done under a watchdog, returns kP or an error.
module ecc_job_ctrl #(
  parameter int W       = 4,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 15000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_job_valid,
  output logic             o_job_ready,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_prime,
  input  logic [W-1:0]     i_k,
  input  logic [W-1:0]     i_px,
  input  logic [W-1:0]     i_py,
  output logic             o_core_rst,
  output logic             o_start,
  output logic [W-1:0]     o_a,
  output logic [W-1:0]     o_prime,
  output logic [W-1:0]     o_k,
  output logic [W-1:0]     o_px,
  output logic [W-1:0]     o_py,
  input  logic [RES_W-1:0] i_core_x,
  input  logic [RES_W-1:0] i_core_y,
  input  logic             i_core_done,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [RES_W-1:0] o_res_x,
  output logic [RES_W-1:0] o_res_y,
  output logic [1:0]       o_res_err,
  output logic [7:0]       o_err_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept, bad_args, timeout_hit, err_inc;

  always_comb begin
    accept      = i_job_valid & o_job_ready;
    bad_args    = (i_prime < W'(3)) | (i_k == '0) | (i_px >= i_prime) | (i_py >= i_prime);
    timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    // Done beats the watchdog when both land in the same cycle.
    err_inc     = ((state == IDLE) & accept & bad_args) |
                  ((state == WAIT) & ~i_core_done & timeout_hit);
    state_nxt   = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_args ? RESP : CLR;
      CLR:     state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (i_core_done || timeout_hit) state_nxt = RESP;
      RESP:    if (i_res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and handshake flags are registered copies of the next-state decode,
  // so no input reaches an output combinationally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_job_ready <= 1'b1;
      o_core_rst  <= 1'b0;
      o_start     <= 1'b0;
      o_res_valid <= 1'b0;
      o_a         <= '0;
      o_prime     <= '0;
      o_k         <= '0;
      o_px        <= '0;
      o_py        <= '0;
      o_res_x     <= '0;
      o_res_y     <= '0;
      o_res_err   <= 2'b00;
      o_err_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      o_job_ready <= (state_nxt == IDLE);
      o_core_rst  <= (state_nxt == CLR);
      o_start     <= (state_nxt == START);
      o_res_valid <= (state_nxt == RESP);
      if (accept) begin
        o_a     <= i_a;
        o_prime <= i_prime;
        o_k     <= i_k;
        o_px    <= i_px;
        o_py    <= i_py;
      end
      if (err_inc && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      case (state)
        IDLE: if (accept && bad_args) begin
          o_res_x   <= '0;
          o_res_y   <= '0;
          o_res_err <= 2'b10;
        end
        START: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (i_core_done) begin
            o_res_x   <= i_core_x;
            o_res_y   <= i_core_y;
            o_res_err <= 2'b00;
          end else if (timeout_hit) begin
            o_res_x   <= '0;
            o_res_y   <= '0;
            o_res_err <= 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_job_ctrl.sv
// Directed bench for ecc_job_ctrl with a short watchdog; the core is modelled
// by driving i_core_done/x/y by hand at chosen WAIT cycles.
module tb_ecc_job_ctrl;
  localparam int W = 4, RES_W = 32, TO = 16;

  logic             i_clk = 1'b0, i_rst = 1'b1;
  logic             i_job_valid = 1'b0, i_res_ready = 1'b0, i_core_done = 1'b0;
  logic [W-1:0]     i_a = '0, i_prime = '0, i_k = '0, i_px = '0, i_py = '0;
  logic [RES_W-1:0] i_core_x = '0, i_core_y = '0;
  logic             o_job_ready, o_core_rst, o_start, o_res_valid;
  logic [W-1:0]     o_a, o_prime, o_k, o_px, o_py;
  logic [RES_W-1:0] o_res_x, o_res_y;
  logic [1:0]       o_res_err;
  logic [7:0]       o_err_cnt;

  int checks = 0, errors = 0, n_start = 0, n_crst = 0;

  ecc_job_ctrl #(.W(W), .RES_W(RES_W), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_a(i_a), .i_prime(i_prime), .i_k(i_k), .i_px(i_px), .i_py(i_py),
    .o_core_rst(o_core_rst), .o_start(o_start),
    .o_a(o_a), .o_prime(o_prime), .o_k(o_k), .o_px(o_px), .o_py(o_py),
    .i_core_x(i_core_x), .i_core_y(i_core_y), .i_core_done(i_core_done),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_x(o_res_x), .o_res_y(o_res_y), .o_res_err(o_res_err), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_start)    n_start++;
    if (o_core_rst) n_crst++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, p, k, x, y);
    i_a = a; i_prime = p; i_k = k; i_px = x; i_py = y;
    i_job_valid = 1'b1;
    tick();
    i_job_valid = 1'b0;
  endtask

  // Accept, then expect CLR in N+1 and START in N+2; returns in the START cycle.
  task automatic launch(input logic [W-1:0] a, p, k, x, y);
    send(a, p, k, x, y);
    chk("clr_pulse", o_core_rst, 1);
    chk("clr_no_start", o_start, 0);
    chk("busy_not_ready", o_job_ready, 0);
    chk("op_k", o_k, k);
    chk("op_px", o_px, x);
    tick();
    chk("start_pulse", o_start, 1);
    chk("start_no_clr", o_core_rst, 0);
  endtask

  // From the START cycle, raise done in WAIT cycle `lat`; returns in the RESP cycle.
  task automatic core_done(input int lat, input logic [RES_W-1:0] x, y);
    repeat (lat) tick();
    chk("no_early_valid", o_res_valid, 0);
    i_core_done = 1'b1; i_core_x = x; i_core_y = y;
    tick();
    i_core_done = 1'b0;
    chk("res_valid", o_res_valid, 1);
  endtask

  task automatic release_res();
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk("hs_valid_low", o_res_valid, 0);
    chk("hs_ready_high", o_job_ready, 1);
  endtask

  initial begin
    int n, s0, c0;
    logic [W-1:0] bad [3][5];
    bad[0] = '{4'd2, 4'd2,  4'd3, 4'd1,  4'd1};
    bad[1] = '{4'd2, 4'd11, 4'd0, 4'd2,  4'd4};
    bad[2] = '{4'd2, 4'd11, 4'd3, 4'd12, 4'd4};

    repeat (3) tick();
    i_rst = 1'b0;
    chk("rst_ready", o_job_ready, 1);
    chk("rst_valid", o_res_valid, 0);
    chk("rst_start", o_start, 0);
    chk("rst_clr", o_core_rst, 0);
    chk("rst_a", o_a, 0);
    chk("rst_resx", o_res_x, 0);
    chk("rst_err", o_res_err, 0);
    chk("rst_errcnt", o_err_cnt, 0);

    // Normal job
    launch(4'd2, 4'd11, 4'd3, 4'd2, 4'd4);
    chk("op_a", o_a, 2);
    chk("op_prime", o_prime, 11);
    core_done(10, 32'h5, 32'h9);
    chk("norm_x", o_res_x, 5);
    chk("norm_y", o_res_y, 9);
    chk("norm_err", o_res_err, 0);
    chk("norm_errcnt", o_err_cnt, 0);
    chk("norm_not_ready", o_job_ready, 0);
    release_res();

    // Bad arguments: response one cycle after accept, core untouched
    s0 = n_start; c0 = n_crst;
    for (int i = 0; i < 3; i++) begin
      send(bad[i][0], bad[i][1], bad[i][2], bad[i][3], bad[i][4]);
      chk("bad_valid", o_res_valid, 1);
      chk("bad_err", o_res_err, 2'b10);
      chk("bad_resx", o_res_x, 0);
      chk("bad_resy", o_res_y, 0);
      release_res();
    end
    chk("bad_no_start", n_start - s0, 0);
    chk("bad_no_clr", n_crst - c0, 0);
    chk("bad_errcnt", o_err_cnt, 3);

    // Normal job so the following timeout must clear a nonzero result
    launch(4'd2, 4'd11, 4'd3, 4'd2, 4'd4);
    core_done(3, 32'hDEAD, 32'hBEEF);
    chk("pre_to_x", o_res_x, 32'hDEAD);
    release_res();

    // Timeout: core never signals done
    launch(4'd2, 4'd11, 4'd3, 4'd2, 4'd4);
    n = 0;
    while (n < 40) begin
      tick();
      if (o_res_valid) break;
      n++;
    end
    chk("to_wait_cycles", n, TO);
    chk("to_err", o_res_err, 2'b01);
    chk("to_x", o_res_x, 0);
    chk("to_y", o_res_y, 0);
    chk("to_errcnt", o_err_cnt, 4);
    release_res();
    launch(4'd1, 4'd7, 4'd2, 4'd3, 4'd4);
    core_done(5, 32'h1234, 32'hABCD);
    chk("after_to_x", o_res_x, 32'h1234);
    chk("after_to_err", o_res_err, 0);
    release_res();

    // Backpressure with a second job waiting
    launch(4'd3, 4'd13, 4'd5, 4'd7, 4'd8);
    core_done(3, 32'h77, 32'h88);
    i_a = 4'd1; i_prime = 4'd7; i_k = 4'd2; i_px = 4'd3; i_py = 4'd4;
    i_job_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_valid", o_res_valid, 1);
      chk("bp_x", o_res_x, 32'h77);
      chk("bp_y", o_res_y, 32'h88);
      chk("bp_not_ready", o_job_ready, 0);
      chk("bp_no_clr", o_core_rst, 0);
      chk("bp_op_k", o_k, 5);
    end
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk("bp_hs_valid", o_res_valid, 0);
    chk("bp_hs_ready", o_job_ready, 1);
    tick();
    i_job_valid = 1'b0;
    chk("bp2_clr", o_core_rst, 1);
    chk("bp2_op_k", o_k, 2);
    chk("bp2_op_a", o_a, 1);
    tick();
    chk("bp2_start", o_start, 1);
    core_done(4, 32'h11, 32'h22);
    chk("bp2_x", o_res_x, 32'h11);
    release_res();

    // Done coincides with the last WAIT cycle
    launch(4'd2, 4'd11, 4'd3, 4'd2, 4'd4);
    core_done(TO, 32'hC0DE, 32'hFACE);
    chk("edge_err", o_res_err, 0);
    chk("edge_x", o_res_x, 32'hC0DE);
    chk("edge_y", o_res_y, 32'hFACE);
    chk("edge_errcnt", o_err_cnt, 4);
    release_res();

    // Reset in the middle of WAIT
    launch(4'd2, 4'd11, 4'd3, 4'd2, 4'd4);
    repeat (5) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mr_ready", o_job_ready, 1);
    chk("mr_valid", o_res_valid, 0);
    chk("mr_a", o_a, 0);
    chk("mr_errcnt", o_err_cnt, 0);
    chk("mr_start", o_start, 0);
    s0 = n_start;
    i_core_done = 1'b1; i_core_x = 32'h99; i_core_y = 32'h98;
    tick();
    i_core_done = 1'b0;
    chk("late_done_valid", o_res_valid, 0);
    chk("late_done_x", o_res_x, 0);
    chk("late_done_ready", o_job_ready, 1);
    chk("late_no_start", n_start - s0, 0);
    launch(4'd2, 4'd11, 4'd3, 4'd2, 4'd4);
    core_done(2, 32'h5, 32'h9);
    chk("mr2_x", o_res_x, 5);
    chk("mr2_err", o_res_err, 0);
    release_res();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
